// File: rtl/duel_timer_arbiter.sv
// ----------------------------------------------------------------------------
// duel_timer_arbiter
//
// Head-to-head round controller for the two-player reaction tester. One shared
// random delay, one shared millisecond counter. Decides who reacted first,
// flags false starts, ties and timeouts, and keeps saturating win tallies.
//
// Ports
//   sys_clk      : system clock
//   rstn         : asynchronous active-low reset
//   tick_1ms     : one-cycle pulse per millisecond (sys_clk domain)
//   start        : one-cycle pulse, begins a round (IDLE only)
//   delay_ms     : random pre-go delay in ms, sampled on an accepted start
//   react_a/b    : player keys, active-high levels, already synchronised
//   ack          : one-cycle pulse, releases RESULT back to IDLE
//   clear_score  : one-cycle pulse, zeroes both tallies (any state)
//   busy         : high in every state except IDLE
//   go           : high only in ARMED ("react now" indicator)
//   result_valid : high only in RESULT
//   winner       : 00 none/timeout, 01 A, 10 B, 11 tie
//   foul         : bit0 A false start, bit1 B false start
//   react_ms     : winning reaction time; TIMEOUT_MS on timeout; 0 on foul
//   wins_a/b     : saturating win tallies
//   state_o      : current state code (IDLE=0, DELAY=1, ARMED=2, RESULT=3)
//
// Control inputs: start, ack and clear_score are single-cycle requests with no
// ready/backpressure. Each is acted on in the cycle it is high if the current
// state honours it; otherwise it is dropped and never remembered. There is no
// valid/ready pairing on this block; result_valid is a level that stays high
// for as long as the round result is presented (until ack).
// ----------------------------------------------------------------------------
module duel_timer_arbiter #(
    parameter int TIMEOUT_MS = 999,
    parameter int CNT_W      = 16,
    parameter int TALLY_W    = 4
) (
    input  logic               sys_clk,
    input  logic               rstn,
    input  logic               tick_1ms,
    input  logic               start,
    input  logic [CNT_W-1:0]   delay_ms,
    input  logic               react_a,
    input  logic               react_b,
    input  logic               ack,
    input  logic               clear_score,
    output logic               busy,
    output logic               go,
    output logic               result_valid,
    output logic [1:0]         winner,
    output logic [1:0]         foul,
    output logic [9:0]         react_ms,
    output logic [TALLY_W-1:0] wins_a,
    output logic [TALLY_W-1:0] wins_b,
    output logic [1:0]         state_o
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DELAY  = 2'd1;
    localparam logic [1:0] S_ARMED  = 2'd2;
    localparam logic [1:0] S_RESULT = 2'd3;

    localparam logic [CNT_W-1:0]   TIMEOUT_CNT = CNT_W'(TIMEOUT_MS);
    localparam logic [9:0]         TIMEOUT_RPT = 10'(TIMEOUT_MS);
    localparam logic [TALLY_W-1:0] TALLY_MAX   = '1;

    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic [CNT_W-1:0] ms_cnt;
    logic [CNT_W-1:0] ms_cnt_nx;
    logic [CNT_W-1:0] ms_inc;
    logic [CNT_W-1:0] delay_lat;
    logic [CNT_W-1:0] delay_lat_nx;
    logic [1:0]       winner_nx;
    logic [1:0]       foul_nx;
    logic [9:0]       react_ms_nx;

    logic prev_a;
    logic prev_b;
    logic press_a;
    logic press_b;
    logic enter_result;

    // Rising-edge press detect. The previous-level registers run in every
    // state, so a key already held when the round starts produces no edge
    // until it is released and pressed again.
    assign press_a = react_a & ~prev_a;
    assign press_b = react_b & ~prev_b;

    assign ms_inc = ms_cnt + CNT_W'(1);

    always_comb begin
        state_nx     = state;
        ms_cnt_nx    = ms_cnt;
        delay_lat_nx = delay_lat;
        winner_nx    = winner;
        foul_nx      = foul;
        react_ms_nx  = react_ms;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx     = S_DELAY;
                    ms_cnt_nx    = '0;
                    // A zero delay would never match ms_cnt+1, so treat it as 1 ms.
                    delay_lat_nx = (delay_ms == '0) ? CNT_W'(1) : delay_ms;
                    winner_nx    = 2'b00;
                    foul_nx      = 2'b00;
                    react_ms_nx  = '0;
                end
            end

            S_DELAY: begin
                // A press during the delay is a false start and beats a
                // delay-expiry tick in the same cycle. The non-fouling player
                // is awarded the round; a double foul awards nobody.
                if (press_a || press_b) begin
                    state_nx    = S_RESULT;
                    foul_nx     = {press_b, press_a};
                    winner_nx   = {press_a & ~press_b, press_b & ~press_a};
                    react_ms_nx = '0;
                end else if (tick_1ms) begin
                    if (ms_inc == delay_lat) begin
                        state_nx  = S_ARMED;
                        ms_cnt_nx = '0;
                    end else begin
                        ms_cnt_nx = ms_inc;
                    end
                end
            end

            S_ARMED: begin
                // Press wins over a same-cycle timeout tick and records the
                // count as it stands in the press cycle.
                if (press_a || press_b) begin
                    state_nx    = S_RESULT;
                    winner_nx   = {press_b, press_a};
                    foul_nx     = 2'b00;
                    react_ms_nx = ms_cnt[9:0];
                end else if (tick_1ms) begin
                    if (ms_inc == TIMEOUT_CNT) begin
                        state_nx    = S_RESULT;
                        winner_nx   = 2'b00;
                        foul_nx     = 2'b00;
                        react_ms_nx = TIMEOUT_RPT;
                    end else begin
                        ms_cnt_nx = ms_inc;
                    end
                end
            end

            S_RESULT: begin
                if (ack) begin
                    state_nx = S_IDLE;
                end
            end

            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Tallies move on the same edge that enters RESULT, so they already
    // include the round by the first cycle result_valid is high.
    assign enter_result = (state != S_RESULT) && (state_nx == S_RESULT);

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            ms_cnt    <= '0;
            delay_lat <= '0;
            winner    <= 2'b00;
            foul      <= 2'b00;
            react_ms  <= '0;
            prev_a    <= 1'b0;
            prev_b    <= 1'b0;
        end else begin
            state     <= state_nx;
            ms_cnt    <= ms_cnt_nx;
            delay_lat <= delay_lat_nx;
            winner    <= winner_nx;
            foul      <= foul_nx;
            react_ms  <= react_ms_nx;
            prev_a    <= react_a;
            prev_b    <= react_b;
        end
    end

    // clear_score overrides an increment landing in the same cycle.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            wins_a <= '0;
            wins_b <= '0;
        end else if (clear_score) begin
            wins_a <= '0;
            wins_b <= '0;
        end else if (enter_result) begin
            if (winner_nx[0] && (wins_a != TALLY_MAX)) begin
                wins_a <= wins_a + TALLY_W'(1);
            end
            if (winner_nx[1] && (wins_b != TALLY_MAX)) begin
                wins_b <= wins_b + TALLY_W'(1);
            end
        end
    end

    assign busy         = (state != S_IDLE);
    assign go           = (state == S_ARMED);
    assign result_valid = (state == S_RESULT);
    assign state_o      = state;

endmodule

// File: tb/tb_duel_timer_arbiter.sv
module tb_duel_timer_arbiter;

    localparam int CNT_W      = 16;
    localparam int TALLY_W    = 4;
    localparam int TIMEOUT_MS = 999;
    localparam int SB_W       = 2 + 2 + 10 + TALLY_W + TALLY_W;
    localparam int TALLY_SAT  = (1 << TALLY_W) - 1;

    // ---------------- clock / reset ----------------
    logic sys_clk = 1'b0;
    logic rstn    = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic               tick_1ms    = 1'b0;
    logic               start       = 1'b0;
    logic [CNT_W-1:0]   delay_ms    = '0;
    logic               react_a     = 1'b0;
    logic               react_b     = 1'b0;
    logic               ack         = 1'b0;
    logic               clear_score = 1'b0;
    logic               busy;
    logic               go;
    logic               result_valid;
    logic [1:0]         winner;
    logic [1:0]         foul;
    logic [9:0]         react_ms;
    logic [TALLY_W-1:0] wins_a;
    logic [TALLY_W-1:0] wins_b;
    logic [1:0]         state_o;

    duel_timer_arbiter #(
        .TIMEOUT_MS(TIMEOUT_MS),
        .CNT_W     (CNT_W),
        .TALLY_W   (TALLY_W)
    ) dut (
        .sys_clk     (sys_clk),
        .rstn        (rstn),
        .tick_1ms    (tick_1ms),
        .start       (start),
        .delay_ms    (delay_ms),
        .react_a     (react_a),
        .react_b     (react_b),
        .ack         (ack),
        .clear_score (clear_score),
        .busy        (busy),
        .go          (go),
        .result_valid(result_valid),
        .winner      (winner),
        .foul        (foul),
        .react_ms    (react_ms),
        .wins_a      (wins_a),
        .wins_b      (wins_b),
        .state_o     (state_o)
    );

    // ---------------- scoreboard state ----------------
    logic [SB_W-1:0] exp_q[$];
    int tests_run    = 0;
    int tests_failed = 0;
    int go_seen      = 0;
    int m_wins_a     = 0;
    int m_wins_b     = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference tally model: winner bit0 credits A, bit1 credits B.
    task automatic model_tally(input logic [1:0] w);
        if (w[0] && m_wins_a < TALLY_SAT) m_wins_a++;
        if (w[1] && m_wins_b < TALLY_SAT) m_wins_b++;
    endtask

    task automatic push_exp(input logic [1:0] w, input logic [1:0] f, input int r);
        logic [9:0] rr;
        rr = 10'(r);
        exp_q.push_back({w, f, rr, TALLY_W'(m_wins_a), TALLY_W'(m_wins_b)});
    endtask

    task automatic expect_result(input logic [1:0] w, input logic [1:0] f, input int r);
        model_tally(w);
        push_exp(w, f, r);
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge sys_clk);
            if (go) go_seen++;
            tick_1ms = 1'b1;
            @(negedge sys_clk);
            tick_1ms = 1'b0;
        end
    endtask

    task automatic start_round(input int d);
        @(negedge sys_clk);
        delay_ms = CNT_W'(d);
        start    = 1'b1;
        @(negedge sys_clk);
        start    = 1'b0;
        go_seen  = 0;
    endtask

    task automatic press(input logic a, input logic b);
        @(negedge sys_clk);
        if (a) react_a = 1'b1;
        if (b) react_b = 1'b1;
    endtask

    task automatic wait_result(input string tag);
        logic [SB_W-1:0] e;
        int n;
        logic found;
        n = 0;
        found = 1'b0;
        while (n < 40 && !found) begin
            @(negedge sys_clk);
            if (go) go_seen++;
            if (result_valid) found = 1'b1;
            n++;
        end
        if (!found) begin
            check_eq($sformatf("%s result_valid", tag), {31'd0, result_valid}, 32'd1);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end else if (exp_q.size() == 0) begin
            check_eq($sformatf("%s exp_queue", tag), 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_eq($sformatf("%s winner", tag),   {30'd0, winner},   {30'd0, e[SB_W-1 -: 2]});
            check_eq($sformatf("%s foul", tag),     {30'd0, foul},     {30'd0, e[SB_W-3 -: 2]});
            check_eq($sformatf("%s react_ms", tag), {22'd0, react_ms}, {22'd0, e[SB_W-5 -: 10]});
            check_eq($sformatf("%s wins_a", tag),   32'(wins_a),       32'(e[2*TALLY_W-1 -: TALLY_W]));
            check_eq($sformatf("%s wins_b", tag),   32'(wins_b),       32'(e[TALLY_W-1 -: TALLY_W]));
        end
    endtask

    task automatic finish_round(input string tag);
        @(negedge sys_clk);
        react_a = 1'b0;
        react_b = 1'b0;
        ack     = 1'b1;
        @(negedge sys_clk);
        ack     = 1'b0;
        check_eq($sformatf("%s idle_state", tag), 32'(state_o), 32'd0);
        check_eq($sformatf("%s idle_busy", tag),  32'(busy),    32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset state
        #12;
        check_eq("rst state_o", 32'(state_o), 32'd0);
        check_eq("rst busy",    32'(busy),    32'd0);
        check_eq("rst go",      32'(go),      32'd0);
        check_eq("rst valid",   32'(result_valid), 32'd0);
        check_eq("rst winner",  32'(winner),  32'd0);
        check_eq("rst wins",    32'({wins_a, wins_b}), 32'd0);
        @(negedge sys_clk);
        rstn = 1'b1;

        // Clean A win: go after exactly 1200 ticks, A at 250
        start_round(1200);
        check_eq("a_win state_delay", 32'(state_o), 32'd1);
        do_ticks(1199);
        check_eq("a_win go_early", 32'(go), 32'd0);
        do_ticks(1);
        check_eq("a_win go_on_time", 32'(go), 32'd1);
        do_ticks(250);
        expect_result(2'b01, 2'b00, 250);
        press(1'b1, 1'b0);
        wait_result("a_win");
        finish_round("a_win");
        check_eq("a_win held_winner", 32'(winner),   32'd1);
        check_eq("a_win held_react",  32'(react_ms), 32'd250);

        // False start by B during a long delay
        start_round(3000);
        check_eq("foul_b cleared_winner", 32'(winner), 32'd0);
        do_ticks(1000);
        expect_result(2'b01, 2'b10, 0);
        press(1'b0, 1'b1);
        wait_result("foul_b");
        check_eq("foul_b go_never", 32'(go_seen), 32'd0);
        finish_round("foul_b");

        // Simultaneous press at 180 ms
        start_round(5);
        do_ticks(5);
        do_ticks(180);
        expect_result(2'b11, 2'b00, 180);
        press(1'b1, 1'b1);
        wait_result("tie");
        finish_round("tie");

        // Timeout, delay_ms of 0 behaves as 1
        start_round(0);
        do_ticks(1);
        check_eq("tmo armed", 32'(state_o), 32'd2);
        do_ticks(TIMEOUT_MS - 1);
        check_eq("tmo not_yet", 32'(state_o), 32'd2);
        expect_result(2'b00, 2'b00, TIMEOUT_MS);
        do_ticks(1);
        wait_result("tmo");
        finish_round("tmo");

        // A press beats the delay-expiry tick in the same cycle
        start_round(4);
        do_ticks(3);
        expect_result(2'b10, 2'b01, 0);
        @(negedge sys_clk);
        tick_1ms = 1'b1;
        react_a  = 1'b1;
        @(negedge sys_clk);
        tick_1ms = 1'b0;
        wait_result("foul_a_vs_expiry");
        check_eq("foul_a_vs_expiry go_never", 32'(go_seen), 32'd0);
        finish_round("foul_a_vs_expiry");

        // Held A never counts, B presses
        @(negedge sys_clk);
        react_a = 1'b1;
        start_round(2);
        do_ticks(2);
        do_ticks(10);
        expect_result(2'b10, 2'b00, 10);
        press(1'b0, 1'b1);
        wait_result("held_a");
        finish_round("held_a");

        // 16 more B wins, random small delays and reaction times
        for (int i = 0; i < 16; i++) begin
            int d;
            int r;
            d = $urandom_range(1, 4);
            r = $urandom_range(0, 6);
            start_round(d);
            do_ticks(d);
            do_ticks(r);
            expect_result(2'b10, 2'b00, r);
            press(1'b0, 1'b1);
            wait_result($sformatf("sat_%0d", i));
            finish_round($sformatf("sat_%0d", i));
        end
        check_eq("sat wins_b", 32'(wins_b), 32'(TALLY_SAT));

        // clear_score on the same cycle as a B win
        start_round(1);
        do_ticks(1);
        m_wins_a = 0;
        m_wins_b = 0;
        push_exp(2'b10, 2'b00, 0);
        @(negedge sys_clk);
        react_b     = 1'b1;
        clear_score = 1'b1;
        @(negedge sys_clk);
        clear_score = 1'b0;
        wait_result("clear_win");

        // start during RESULT is dropped
        @(negedge sys_clk);
        delay_ms = CNT_W'(7);
        start    = 1'b1;
        @(negedge sys_clk);
        start    = 1'b0;
        check_eq("start_in_result state", 32'(state_o), 32'd3);
        check_eq("start_in_result winner", 32'(winner), 32'd2);
        finish_round("start_in_result");
        repeat (3) @(negedge sys_clk);
        check_eq("start_dropped state", 32'(state_o), 32'd0);

        // A win so the tallies are non-zero, then async reset mid-ARMED
        start_round(1);
        do_ticks(1);
        do_ticks(3);
        expect_result(2'b01, 2'b00, 3);
        press(1'b1, 1'b0);
        wait_result("pre_reset");
        finish_round("pre_reset");
        check_eq("pre_reset wins_a", 32'(wins_a), 32'd1);

        start_round(2);
        do_ticks(2);
        do_ticks(5);
        check_eq("rst_mid go", 32'(go), 32'd1);
        @(posedge sys_clk);
        #2;
        rstn = 1'b0;
        #1;
        m_wins_a = 0;
        m_wins_b = 0;
        check_eq("rst_mid state_o", 32'(state_o), 32'd0);
        check_eq("rst_mid go",      32'(go),      32'd0);
        check_eq("rst_mid busy",    32'(busy),    32'd0);
        check_eq("rst_mid wins_a",  32'(wins_a),  32'(m_wins_a));
        check_eq("rst_mid winner",  32'(winner),  32'd0);
        @(negedge sys_clk);
        rstn = 1'b1;
        repeat (2) @(negedge sys_clk);
        check_eq("post_rst state_o", 32'(state_o), 32'd0);
        check_eq("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
